// File: rtl/pwm_dimmer_pkg.sv
// -----------------------------------------------------------------------------
// pwm_dimmer_pkg
// Purpose : Shared defaults for the PWM dimmer block. Holds the default
//           period-counter width, PWM period, brightness step and reset duty,
//           plus the derived duty width (one bit wider than the counter so
//           that a duty of exactly PERIOD can be represented).
// Ports   : none (package)
// Config  : BTN_SYNC_EN (see btn_edge) selects a two-flop button synchronizer.
// -----------------------------------------------------------------------------
package pwm_dimmer_pkg;

  localparam int DEF_CNT_W    = 8;
  localparam int DEF_PERIOD   = 256;
  localparam int DEF_STEP     = 16;
  localparam int DEF_DUTY_RST = 0;

  // Duty spans 0..PERIOD and PERIOD may equal 2**CNT_W, hence the extra bit.
  localparam int DEF_DUTY_W   = DEF_CNT_W + 1;

  // Duty width derived from any counter width.
  function automatic int duty_width(input int cnt_w);
    return cnt_w + 1;
  endfunction

endpackage : pwm_dimmer_pkg

// File: rtl/pwm_dimmer_if.sv
// -----------------------------------------------------------------------------
// pwm_dimmer_if
// Purpose : Groups the dimmer control inputs and PWM/status outputs.
// Signals : en           - dimmer enable (master -> slave)
//           btn_up       - brightness-up button, level, active-high
//           btn_down     - brightness-down button, level, active-high
//           pwm          - registered PWM drive (slave -> master)
//           duty         - programmed duty, 0..PERIOD (slave -> master)
//           period_start - one-cycle pulse aligned with the cnt==0 pwm sample
// Modports: master (controller / bench side), slave (pwm_dimmer side)
// Config  : BTN_SYNC_EN has no effect on this interface.
// -----------------------------------------------------------------------------
interface pwm_dimmer_if
  import pwm_dimmer_pkg::*;
#(
  parameter int DUTY_W = DEF_DUTY_W
) ();

  logic              en;
  logic              btn_up;
  logic              btn_down;
  logic              pwm;
  logic [DUTY_W-1:0] duty;
  logic              period_start;

  modport master (
    output en,
    output btn_up,
    output btn_down,
    input  pwm,
    input  duty,
    input  period_start
  );

  modport slave (
    input  en,
    input  btn_up,
    input  btn_down,
    output pwm,
    output duty,
    output period_start
  );

endinterface : pwm_dimmer_if

// File: rtl/btn_edge.sv
// -----------------------------------------------------------------------------
// btn_edge
// Purpose : Rising-edge detector for one push-button level input, with an
//           optional two-flop synchronizer in front of it.
// Ports   : clk    - system clock
//           rst_n  - synchronous active-low reset
//           i_btn  - raw button level, active-high
//           o_edge - high for the cycle in which the (synchronized) button
//                    level is 1 and was 0 on the previous clock
// Config  : BTN_SYNC_EN defined   -> i_btn passes through two flops first;
//                                    button rise to duty change is 3 edges.
//           BTN_SYNC_EN undefined -> i_btn feeds the detector directly;
//                                    button rise to duty change is 1 edge.
// -----------------------------------------------------------------------------
module btn_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_edge
);

  logic w_btn;
  logic r_btn_q;

`ifdef BTN_SYNC_EN
  logic r_sync1;
  logic r_sync2;

  // Two-flop synchronizer for the asynchronous button level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
    end
  end

  assign w_btn = r_sync2;
`else
  assign w_btn = i_btn;
`endif

  // Previous-cycle button level for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_btn_q <= 1'b0;
    end else begin
      r_btn_q <= w_btn;
    end
  end

  // A held button produces exactly one edge.
  assign o_edge = w_btn & ~r_btn_q;

endmodule : btn_edge

// File: rtl/pwm_dimmer.sv
// -----------------------------------------------------------------------------
// pwm_dimmer
// Purpose : Produces the single PWM line copied onto the board LEDs. A duty
//           register is stepped up/down by two buttons; a free-running period
//           counter compares against a shadow copy of the duty that is only
//           reloaded at period boundaries, so no period is ever glitched.
// Ports   : clk   - system clock
//           rst_n - synchronous active-low reset
//           bus   - pwm_dimmer_if.slave: en, btn_up, btn_down in;
//                   pwm, duty, period_start out (all registered)
// Params  : CNT_W    - period counter width
//           PERIOD   - PWM period in clocks, 2..2**CNT_W
//           STEP     - duty change per button press, >= 1
//           DUTY_RST - duty after reset, <= PERIOD
// Config  : BTN_SYNC_EN adds a two-flop synchronizer per button (btn_edge).
//           PWM and counter timing are the same in both builds.
// -----------------------------------------------------------------------------
module pwm_dimmer
  import pwm_dimmer_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int PERIOD   = DEF_PERIOD,
  parameter int STEP     = DEF_STEP,
  parameter int DUTY_RST = DEF_DUTY_RST
) (
  input  logic         clk,
  input  logic         rst_n,
  pwm_dimmer_if.slave  bus
);

  localparam int DW = CNT_W + 1;
  localparam int AW = CNT_W + 2;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [DW-1:0]    DUTY_RST_V = DW'(DUTY_RST);
  localparam logic [DW-1:0]    PERIOD_D   = DW'(PERIOD);
  localparam logic [AW-1:0]    PERIOD_A   = AW'(PERIOD);
  localparam logic [AW-1:0]    STEP_A     = AW'(STEP);

  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_duty;
  logic [DW-1:0]    r_duty_active;
  logic             r_pwm;
  logic             r_period_start;

  logic             w_up_edge;
  logic             w_down_edge;
  logic             w_cnt_last;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_pwm_nxt;
  logic [AW-1:0]    w_duty_ext;
  logic [AW-1:0]    w_duty_sum;
  logic [AW-1:0]    w_duty_diff;
  logic [DW-1:0]    w_duty_nxt;

  btn_edge u_btn_up (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (bus.btn_up),
    .o_edge (w_up_edge)
  );

  btn_edge u_btn_down (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_btn  (bus.btn_down),
    .o_edge (w_down_edge)
  );

  // Counter wrap and the PWM compare (counter extended to duty width so a
  // duty of PERIOD keeps the output high for the whole period).
  always_comb begin
    w_cnt_last = (r_cnt == CNT_LAST);
    w_cnt_nxt  = r_cnt + CNT_ONE;
    if (w_cnt_last) begin
      w_cnt_nxt = '0;
    end else begin
      w_cnt_nxt = r_cnt + CNT_ONE;
    end
    w_pwm_nxt = bus.en && ({1'b0, r_cnt} < r_duty_active);
  end

  // Next programmed duty; two extra bits of headroom keep the saturation
  // compare free of wrap-around.
  always_comb begin
    w_duty_ext  = {1'b0, r_duty};
    w_duty_sum  = w_duty_ext + STEP_A;
    w_duty_diff = w_duty_ext - STEP_A;
    w_duty_nxt  = r_duty;
    if (w_up_edge && !w_down_edge) begin
      if (w_duty_sum > PERIOD_A) begin
        w_duty_nxt = PERIOD_D;
      end else begin
        w_duty_nxt = w_duty_sum[DW-1:0];
      end
    end else if (w_down_edge && !w_up_edge) begin
      if (w_duty_ext >= STEP_A) begin
        w_duty_nxt = w_duty_diff[DW-1:0];
      end else begin
        w_duty_nxt = '0;
      end
    end else begin
      w_duty_nxt = r_duty;
    end
  end

  // Programmed duty register; buttons act whether or not the dimmer is enabled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_duty <= DUTY_RST_V;
    end else begin
      r_duty <= w_duty_nxt;
    end
  end

  // Period counter, shadow duty and registered PWM/period_start outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt          <= '0;
      r_duty_active  <= DUTY_RST_V;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
    end else if (bus.en) begin
      r_cnt          <= w_cnt_nxt;
      r_pwm          <= w_pwm_nxt;
      r_period_start <= (r_cnt == '0);
      // Shadow reload on the last count so the new duty is first seen on
      // the sample that coincides with period_start.
      if (w_cnt_last) begin
        r_duty_active <= r_duty;
      end else begin
        r_duty_active <= r_duty_active;
      end
    end else begin
      // Disabled: counter frozen, output low, shadow follows the duty so the
      // latest value is used as soon as counting resumes.
      r_cnt          <= r_cnt;
      r_pwm          <= 1'b0;
      r_period_start <= 1'b0;
      r_duty_active  <= r_duty;
    end
  end

  assign bus.pwm          = r_pwm;
  assign bus.duty         = r_duty;
  assign bus.period_start = r_period_start;

endmodule : pwm_dimmer
